// File: rtl/ahb_input_hold_stage.sv
// Master-side input stage of the AHB bus matrix: forwards address phases to the
// output arbiter and holds a blocked address phase, stalling the master, until granted.
module ahb_input_hold_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  grant_in,
  input  logic                  ready_in,
  input  logic                  resp_in,
  output logic                  req_out,
  output logic                  sel_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [1:0]            trans_out,
  output logic                  write_out,
  output logic [2:0]            size_out,
  output logic [2:0]            burst_out,
  output logic [3:0]            prot_out,
  output logic                  lock_out,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   acc;
  logic   capture;

  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [1:0]            hold_trans;
  logic                  hold_write;
  logic [2:0]            hold_size;
  logic [2:0]            hold_burst;
  logic [3:0]            hold_prot;
  logic                  hold_lock;

  // Only NONSEQ/SEQ (HTRANS[1]=1) qualified by master HREADY are real address phases.
  assign acc = HSELS & HTRANSS[1] & HREADYS;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (grant_in) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            capture = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (grant_in) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ready_in) begin
          if (acc && grant_in) begin
            state_d = ST_DATA;
          end else if (acc) begin
            state_d = ST_WAIT;
            capture = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hold registers load only on entry to WAIT, so they stay stable while stalled.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_addr  <= '0;
      hold_trans <= '0;
      hold_write <= 1'b0;
      hold_size  <= '0;
      hold_burst <= '0;
      hold_prot  <= '0;
      hold_lock  <= 1'b0;
    end else if (capture) begin
      hold_addr  <= HADDRS;
      hold_trans <= HTRANSS;
      hold_write <= HWRITES;
      hold_size  <= HSIZES;
      hold_burst <= HBURSTS;
      hold_prot  <= HPROTS;
      hold_lock  <= HMASTLOCKS;
    end
  end

  always_comb begin
    addr_out  = HADDRS;
    trans_out = HTRANSS;
    write_out = HWRITES;
    size_out  = HSIZES;
    burst_out = HBURSTS;
    prot_out  = HPROTS;
    lock_out  = HMASTLOCKS;
    sel_out   = HSELS & ~HRESET;
    req_out   = HSELS & HTRANSS[1] & ~HRESET;
    if (state_q == ST_WAIT) begin
      addr_out  = hold_addr;
      trans_out = hold_trans;
      write_out = hold_write;
      size_out  = hold_size;
      burst_out = hold_burst;
      prot_out  = hold_prot;
      lock_out  = hold_lock;
      sel_out   = 1'b1;
      req_out   = 1'b1;
    end
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    case (state_q)
      ST_WAIT: HREADYOUTS = 1'b0;
      ST_DATA: begin
        HREADYOUTS = ready_in;
        HRESPS     = resp_in;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_ahb_input_hold_stage.sv
// Directed bench for ahb_input_hold_stage: granted, blocked, burst, lost-grant,
// ERROR and reset-in-WAIT sequences with hand-computed expectations.
module tb_ahb_input_hold_stage;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hlock;
  logic        hready;
  logic        grant;
  logic        ready;
  logic        resp;
  logic        req_out;
  logic        sel_out;
  logic [31:0] addr_out;
  logic [1:0]  trans_out;
  logic        write_out;
  logic [2:0]  size_out;
  logic [2:0]  burst_out;
  logic [3:0]  prot_out;
  logic        lock_out;
  logic        hreadyout;
  logic        hresp;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  ahb_input_hold_stage #(.ADDR_WIDTH(32)) dut (
    .HCLK(clk), .HRESET(rst), .HSELS(hsel), .HADDRS(haddr), .HTRANSS(htrans),
    .HWRITES(hwrite), .HSIZES(hsize), .HBURSTS(hburst), .HPROTS(hprot),
    .HMASTLOCKS(hlock), .HREADYS(hready), .grant_in(grant), .ready_in(ready),
    .resp_in(resp), .req_out(req_out), .sel_out(sel_out), .addr_out(addr_out),
    .trans_out(trans_out), .write_out(write_out), .size_out(size_out),
    .burst_out(burst_out), .prot_out(prot_out), .lock_out(lock_out),
    .HREADYOUTS(hreadyout), .HRESPS(hresp), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic s, input logic [31:0] a, input logic [1:0] t,
                     input logic w, input logic [2:0] b, input logic l, input logic r);
    hsel = s; haddr = a; htrans = t; hwrite = w; hburst = b; hlock = l; hready = r;
  endtask

  task automatic slave(input logic g, input logic rd, input logic rs);
    grant = g; ready = rd; resp = rs;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    hsize = 3'd2; hprot = 4'h3;
    bus(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 1'b0);
    #2;
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_hready", hreadyout, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    bus(1'b1, 32'h55, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b1);
    #1;
    chk("rst_req", req_out, 1'b0);
    chk("rst_sel", sel_out, 1'b0);
    chk("rst_trans_live", trans_out, T_NSEQ);
    tick(); tick();
    bus(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;
    tick();

    // BUSY and unselected transfers pass through and are never captured
    bus(1'b1, 32'h10, T_BUSY, 1'b0, 3'd0, 1'b0, 1'b1);
    #1;
    chk("busy_trans", trans_out, T_BUSY);
    chk("busy_req", req_out, 1'b0);
    chk("busy_sel", sel_out, 1'b1);
    tick();
    chk("busy_state", state_dbg, S_IDLE);
    bus(1'b0, 32'h20, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b1);
    #1;
    chk("nosel_req", req_out, 1'b0);
    tick();
    chk("nosel_state", state_dbg, S_IDLE);

    // Granted single
    bus(1'b1, 32'h1000, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b1);
    slave(1'b1, 1'b1, 1'b0);
    #1;
    chk("g1_addr", addr_out, 32'h1000);
    chk("g1_req", req_out, 1'b1);
    chk("g1_hready", hreadyout, 1'b1);
    tick();
    chk("g1_state_data", state_dbg, S_DATA);
    bus(1'b1, 32'h0, T_IDLE, 1'b0, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 1'b0);
    #1;
    chk("g1_data_hready", hreadyout, 1'b1);
    tick();
    chk("g1_back_idle", state_dbg, S_IDLE);

    // Blocked write, master changes address while stalled
    bus(1'b1, 32'h2000, T_NSEQ, 1'b1, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 1'b0);
    #1;
    chk("b_req", req_out, 1'b1);
    tick();
    bus(1'b1, 32'h3000, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("b_state_wait", state_dbg, S_WAIT);
      chk("b_hready", hreadyout, 1'b0);
      chk("b_addr_held", addr_out, 32'h2000);
      chk("b_write_held", write_out, 1'b1);
      chk("b_req_wait", req_out, 1'b1);
      tick();
    end
    slave(1'b1, 1'b1, 1'b0);
    #1;
    chk("b_c4_hready", hreadyout, 1'b0);
    chk("b_c4_addr", addr_out, 32'h2000);
    tick();
    chk("b_state_data", state_dbg, S_DATA);
    bus(1'b1, 32'h0, T_IDLE, 1'b0, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 1'b0);
    tick();
    chk("b_back_idle", state_dbg, S_IDLE);

    // INCR4 at 0x40..0x4C, one wait state per beat
    bus(1'b1, 32'h40, T_NSEQ, 1'b0, 3'd3, 1'b0, 1'b1);
    slave(1'b1, 1'b1, 1'b0);
    #1;
    chk("i4_addr0", addr_out, 32'h40);
    tick();
    for (int beat = 1; beat <= 4; beat++) begin
      if (beat < 4) bus(1'b1, 32'h40 + 32'(4 * beat), T_SEQ, 1'b0, 3'd3, 1'b0, 1'b0);
      else          bus(1'b1, 32'h0, T_IDLE, 1'b0, 3'd0, 1'b0, 1'b0);
      slave(1'b0, 1'b0, 1'b0);
      #1;
      chk("i4_wait_state", state_dbg, S_DATA);
      chk("i4_wait_hready", hreadyout, 1'b0);
      tick();
      hready = 1'b1;
      slave(beat < 4, 1'b1, 1'b0);
      #1;
      chk("i4_ready_state", state_dbg, S_DATA);
      chk("i4_ready_hready", hreadyout, 1'b1);
      if (beat < 4) chk("i4_addr", addr_out, 32'h40 + 32'(4 * beat));
      tick();
    end
    chk("i4_end_idle", state_dbg, S_IDLE);

    // Lost grant mid-stream
    bus(1'b1, 32'h60, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b1);
    slave(1'b1, 1'b1, 1'b0);
    tick();
    bus(1'b1, 32'h80, T_NSEQ, 1'b0, 3'd0, 1'b1, 1'b1);
    slave(1'b0, 1'b1, 1'b0);
    #1;
    chk("lg_hready", hreadyout, 1'b1);
    tick();
    bus(1'b1, 32'h90, T_SEQ, 1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    chk("lg_state", state_dbg, S_WAIT);
    chk("lg_addr", addr_out, 32'h80);
    chk("lg_lock", lock_out, 1'b1);
    chk("lg_trans", trans_out, T_NSEQ);
    chk("lg_size", size_out, 3'd2);
    chk("lg_prot", prot_out, 4'h3);
    slave(1'b1, 1'b1, 1'b0);
    tick();
    chk("lg_data", state_dbg, S_DATA);
    bus(1'b1, 32'h0, T_IDLE, 1'b0, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 1'b0);
    tick();

    // Two-cycle ERROR, master cancels with IDLE
    bus(1'b1, 32'hA0, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b1);
    slave(1'b1, 1'b1, 1'b0);
    tick();
    bus(1'b1, 32'hA4, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b0);
    slave(1'b0, 1'b0, 1'b1);
    #1;
    chk("e1_hresp", hresp, 1'b1);
    chk("e1_hready", hreadyout, 1'b0);
    tick();
    bus(1'b1, 32'h0, T_IDLE, 1'b0, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 1'b1);
    #1;
    chk("e2_hresp", hresp, 1'b1);
    chk("e2_hready", hreadyout, 1'b1);
    tick();
    slave(1'b0, 1'b1, 1'b0);
    #1;
    chk("e_idle", state_dbg, S_IDLE);
    chk("e_hresp_clr", hresp, 1'b0);

    // Reset while stalled in WAIT
    bus(1'b1, 32'hC0, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    hready = 1'b0;
    #1;
    chk("rw_wait", state_dbg, S_WAIT);
    chk("rw_hready0", hreadyout, 1'b0);
    rst = 1'b1;
    #1;
    chk("rw_hready1", hreadyout, 1'b1);
    chk("rw_req", req_out, 1'b0);
    chk("rw_sel", sel_out, 1'b0);
    chk("rw_state", state_dbg, S_IDLE);
    chk("rw_addr_live", addr_out, 32'hC0);
    tick();
    rst = 1'b0;
    bus(1'b1, 32'hD0, T_NSEQ, 1'b0, 3'd0, 1'b0, 1'b1);
    #1;
    chk("rw_post_hready", hreadyout, 1'b1);
    tick();
    bus(1'b1, 32'hE0, T_SEQ, 1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    chk("rw_post_wait", state_dbg, S_WAIT);
    chk("rw_post_addr", addr_out, 32'hD0);
    slave(1'b1, 1'b1, 1'b0);
    tick();
    chk("rw_post_data", state_dbg, S_DATA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
